icb_clk_align_multilane: RTL and testbench
==========================================

Name: icb_clk_align_multilane

Overview:
Multi-lane successor to the single-lane ICB BCLK/SCLK alignment trainer. It sweeps the ICB tap delay of NUM_LANES lanes one lane at a time and records the contiguous "good" window for each lane, where EARLY, LATE and OOR are all low. It then loads each lane with window centre plus a programmable offset. It sits between fabric training control and the IOD DEM/ICB controls of each lane, and drives a shared pause to the lane datapaths while training.

Parameters:
NUM_LANES, 4, number of lanes trained (1..16).
TAP_CNT_WIDTH, 8, tap code width; taps 0..2^TAP_CNT_WIDTH-1 (8 = 256 taps, 7 = 128 taps).
TAP_WAIT_CNT_WIDTH, 3, settle wait after each LOAD/MOVE = 2^TAP_WAIT_CNT_WIDTH SCLK cycles.
SKIP_TRNG, 0, 1 = training is never performed; behaves as if CLK_ALGN_SKIP is permanently high.

Ports:
SCLK  in  1  system clock; all logic is on the rising edge.
RESET  in  1  asynchronous, active-high reset.
TRAIN_START  in  1  rising edge launches training.
CLK_ALGN_RSTRT  in  1  level; aborts the current run and relaunches from lane 0.
CLK_ALGN_HOLD  in  1  level; freezes the FSM and all counters.
CLK_ALGN_SKIP  in  1  sampled on launch; loads offset taps without sweeping.
TAP_OFFSET  in  TAP_CNT_WIDTH  signed offset added to the window centre.
IOD_EARLY  in  NUM_LANES  per-lane DEM early flag.
IOD_LATE  in  NUM_LANES  per-lane DEM late flag.
IOD_OOR  in  NUM_LANES  per-lane out-of-range flag.
CLK_ALGN_LOAD  out  NUM_LANES  one-cycle load pulse, per lane.
CLK_ALGN_MOV  out  NUM_LANES  one-cycle single-tap move pulse, per lane.
CLK_ALGN_DIR  out  NUM_LANES  move direction; 1 = increment.
CLK_ALGN_CLR_FLGS  out  NUM_LANES  one-cycle clear of DEM flags, per lane.
CLK_ALGN_TAPDLY  out  NUM_LANES*TAP_CNT_WIDTH  per-lane tap code; lane i occupies slice [i*W +: W].
TRAIN_DONE  out  1  high when all lanes are finished; held until relaunch.
CLK_ALGN_ERR  out  NUM_LANES  sticky per-lane "no good tap" error.
ALGN_PAUSE  out  1  high while sweeping; lane datapaths are held.

Behaviour:
- Reset values: all pulses 0, DIR all 1, TAPDLY all 0, TRAIN_DONE 0, ERR 0, ALGN_PAUSE 0, FSM in IDLE.
- Reset may assert at any time, including mid-sweep; the block returns to the reset values immediately.
- TRAIN_START is edge-detected through a one-flop delay. The launch edge is accepted in IDLE or DONE.
- On launch: TRAIN_DONE→0, ERR→0, lane index→0.
- FSM states: IDLE, SKIPLD, CLR, LOAD0, WAIT, SAMPLE, MOVE, CALC, LOADC, NEXT, DONE.
- Launch routing:
  - If CLK_ALGN_SKIP=1 or SKIP_TRNG=1 at launch: enter SKIPLD.
  - SKIPLD drives TAPDLY = TAP_OFFSET (unsigned) on every lane and pulses LOAD on all lanes for 1 cycle.
  - SKIPLD then goes to DONE. ALGN_PAUSE stays 0 throughout.
  - Otherwise: enter CLR with ALGN_PAUSE=1.
- CLR: pulse CLR_FLGS on the current lane → LOAD0.
- LOAD0: TAPDLY[lane]=0, LOAD pulse, tap counter=0, window-valid=0 → WAIT.
- WAIT: count 2^TAP_WAIT_CNT_WIDTH cycles → SAMPLE.
- SAMPLE: good = !EARLY & !LATE & !OOR for the current lane.
  - First good tap: start = end = tap, valid = 1.
  - Good and contiguous with an open window: end = tap.
  - First bad tap after the window has opened closes it → CALC.
  - Tap at maximum → CALC.
  - Otherwise → MOVE.
- MOVE: DIR=1, MOV pulse plus CLR_FLGS pulse in the same cycle, tap+1, TAPDLY tracks tap → WAIT.
- CALC:
  - valid=0: set ERR[lane], TAPDLY[lane]=0.
  - valid=1: centre = (start+end)>>1, computed with a W+1-bit sum. Result = centre + sign-extended TAP_OFFSET, saturated to 0 and 2^W-1.
  - → LOADC.
- LOADC: drive TAPDLY[lane]=result, LOAD pulse → NEXT.
- NEXT: if lane = NUM_LANES-1 → DONE; else lane+1 → CLR.
- DONE: TRAIN_DONE=1, ALGN_PAUSE=0. Stays in DONE until a launch edge or RSTRT.
- Only the current lane's pulses can assert. Other lanes hold their TAPDLY.
- HOLD=1: state, counters and TAPDLY are frozen and no pulses are issued. HOLD has priority over launch.
- RSTRT=1, when HOLD=0:
  - Next cycle: FSM→CLR, lane→0, ERR cleared, TRAIN_DONE=0, ALGN_PAUSE=1.
  - Holding RSTRT high keeps the FSM in CLR.
  - RSTRT and TRAIN_START rising together: RSTRT wins (same resulting behaviour).
- Latency from launch to first CLR_FLGS pulse is 2 cycles.
- Per-tap step is 2^TAP_WAIT_CNT_WIDTH + 2 cycles.

Test Plan:
1. Config NUM_LANES=2, W=4, WAIT=1. Lane0 good taps 5..9, lane1 good taps 2..3, TAP_OFFSET=0. Required: lane0 LOAD with TAPDLY=7, lane1 LOAD with TAPDLY=2, TRAIN_DONE=1, ERR=00, ALGN_PAUSE falls when DONE is entered.
2. Lane0 never good → ERR[0]=1, TAPDLY0=0. Lane1 still trains normally. TRAIN_DONE=1.
3. Lane0 window 12..15 (open at max tap), TAP_OFFSET=+3. Required: centre 13 → 16 saturates to 15. Lane0 window 0..1 with TAP_OFFSET=-2 saturates to 0.
4. CLK_ALGN_SKIP=1 at launch with TAP_OFFSET=6. Required: no MOV pulses, all lanes LOAD once with TAPDLY=6, TRAIN_DONE within 3 cycles, ALGN_PAUSE never asserts.
5. HOLD asserted for 20 cycles mid-sweep. Required: no pulses and tap unchanged during HOLD; final results equal to the no-HOLD run.
6. RSTRT pulse mid lane1, then RESET mid-sweep. Required: RSTRT restarts at lane0 with ERR cleared. RESET returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/icb_clk_align_multilane.sv
// icb_clk_align_multilane: sweeps each lane's ICB tap delay, finds its first good window and loads centre plus offset
module icb_clk_align_multilane #(
  parameter int NUM_LANES          = 4,
  parameter int TAP_CNT_WIDTH      = 8,
  parameter int TAP_WAIT_CNT_WIDTH = 3,
  parameter bit SKIP_TRNG          = 1'b0
) (
  input  logic                               SCLK,
  input  logic                               RESET,
  input  logic                               TRAIN_START,
  input  logic                               CLK_ALGN_RSTRT,
  input  logic                               CLK_ALGN_HOLD,
  input  logic                               CLK_ALGN_SKIP,
  input  logic [TAP_CNT_WIDTH-1:0]           TAP_OFFSET,
  input  logic [NUM_LANES-1:0]               IOD_EARLY,
  input  logic [NUM_LANES-1:0]               IOD_LATE,
  input  logic [NUM_LANES-1:0]               IOD_OOR,
  output logic [NUM_LANES-1:0]               CLK_ALGN_LOAD,
  output logic [NUM_LANES-1:0]               CLK_ALGN_MOV,
  output logic [NUM_LANES-1:0]               CLK_ALGN_DIR,
  output logic [NUM_LANES-1:0]               CLK_ALGN_CLR_FLGS,
  output logic [NUM_LANES*TAP_CNT_WIDTH-1:0] CLK_ALGN_TAPDLY,
  output logic                               TRAIN_DONE,
  output logic [NUM_LANES-1:0]               CLK_ALGN_ERR,
  output logic                               ALGN_PAUSE
);
  localparam int W  = TAP_CNT_WIDTH;
  localparam int LW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  typedef enum logic [3:0] {IDLE, SKIPLD, CLR, LOAD0, WAIT, SAMPLE, MOVE, CALC, LOADC, NEXT, DONE} state_t;
  state_t                       state_q, state_d;
  logic                         ts_q;
  logic [LW-1:0]                lane_q, lane_d;
  logic [W-1:0]                 tap_q, tap_d, win_lo_q, win_lo_d, win_hi_q, win_hi_d, res_q, res_d;
  logic                         valid_q, valid_d, done_q, done_d, pause_q, pause_d;
  logic [TAP_WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_LANES-1:0]         err_q, err_d, load_q, load_d, mov_q, mov_d, clr_q, clr_d;
  logic [NUM_LANES*W-1:0]       tapdly_q, tapdly_d;
  logic                         launch, skip, good;
  logic [NUM_LANES-1:0]         lane_mask;
  logic [W:0]                   sum;
  logic [W+1:0]                 adj;
  logic [W-1:0]                 sat;
  assign launch    = TRAIN_START & ~ts_q;
  assign skip      = CLK_ALGN_SKIP | SKIP_TRNG;
  assign good      = ~(IOD_EARLY[lane_q] | IOD_LATE[lane_q] | IOD_OOR[lane_q]);
  assign lane_mask = NUM_LANES'(1) << lane_q;
  assign sum       = {1'b0, win_lo_q} + {1'b0, win_hi_q};
  assign adj       = {2'b00, sum[W:1]} + {{2{TAP_OFFSET[W-1]}}, TAP_OFFSET};
  assign sat       = adj[W+1] ? '0 : adj[W] ? '1 : adj[W-1:0];
  // Next-state, window tracking and next pulse/tap values; HOLD freezes everything, RSTRT beats launch
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    tap_d    = tap_q;
    win_lo_d = win_lo_q;
    win_hi_d = win_hi_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    err_d    = err_q;
    done_d   = done_q;
    pause_d  = pause_q;
    load_d   = '0;
    mov_d    = '0;
    clr_d    = '0;
    tapdly_d = tapdly_q;
    if (!CLK_ALGN_HOLD) begin
      if (CLK_ALGN_RSTRT) begin
        state_d = CLR;
        lane_d  = '0;
        err_d   = '0;
        done_d  = 1'b0;
        pause_d = 1'b1;
      end else if (launch && (state_q == IDLE || state_q == DONE)) begin
        state_d = skip ? SKIPLD : CLR;
        lane_d  = '0;
        err_d   = '0;
        done_d  = 1'b0;
        pause_d = ~skip;
      end else begin
        case (state_q)
          SKIPLD: begin
            load_d   = '1;
            tapdly_d = {NUM_LANES{TAP_OFFSET}};
            done_d   = 1'b1;
            state_d  = DONE;
          end
          CLR: begin
            clr_d   = lane_mask;
            state_d = LOAD0;
          end
          LOAD0: begin
            load_d                    = lane_mask;
            tapdly_d[lane_q*W +: W]   = '0;
            tap_d                     = '0;
            valid_d                   = 1'b0;
            cnt_d                     = '0;
            state_d                   = WAIT;
          end
          WAIT: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = &cnt_q ? SAMPLE : WAIT;
          end
          SAMPLE: begin
            win_lo_d = (good && !valid_q) ? tap_q : win_lo_q;
            win_hi_d = good ? tap_q : win_hi_q;
            valid_d  = valid_q | good;
            state_d  = ((!good && valid_q) || &tap_q) ? CALC : MOVE;
          end
          MOVE: begin
            mov_d                   = lane_mask;
            clr_d                   = lane_mask;
            tap_d                   = tap_q + 1'b1;
            tapdly_d[lane_q*W +: W] = tap_q + 1'b1;
            state_d                 = WAIT;
          end
          CALC: begin
            res_d         = valid_q ? sat : '0;
            err_d[lane_q] = err_q[lane_q] | ~valid_q;
            if (!valid_q) tapdly_d[lane_q*W +: W] = '0;
            state_d       = LOADC;
          end
          LOADC: begin
            load_d                  = lane_mask;
            tapdly_d[lane_q*W +: W] = res_q;
            state_d                 = NEXT;
          end
          NEXT: begin
            state_d = (lane_q == LW'(NUM_LANES - 1)) ? DONE : CLR;
            lane_d  = (lane_q == LW'(NUM_LANES - 1)) ? lane_q : lane_q + 1'b1;
            done_d  = (lane_q == LW'(NUM_LANES - 1));
            pause_d = (lane_q != LW'(NUM_LANES - 1));
          end
          default: state_d = state_q;
        endcase
      end
    end
  end
  // State, counters and registered outputs with asynchronous reset
  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      ts_q     <= 1'b0;
      lane_q   <= '0;
      tap_q    <= '0;
      win_lo_q <= '0;
      win_hi_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      err_q    <= '0;
      done_q   <= 1'b0;
      pause_q  <= 1'b0;
      load_q   <= '0;
      mov_q    <= '0;
      clr_q    <= '0;
      tapdly_q <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= TRAIN_START;
      lane_q   <= lane_d;
      tap_q    <= tap_d;
      win_lo_q <= win_lo_d;
      win_hi_q <= win_hi_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
      done_q   <= done_d;
      pause_q  <= pause_d;
      load_q   <= load_d;
      mov_q    <= mov_d;
      clr_q    <= clr_d;
      tapdly_q <= tapdly_d;
    end
  end
  assign CLK_ALGN_LOAD     = load_q;
  assign CLK_ALGN_MOV      = mov_q;
  assign CLK_ALGN_DIR      = '1;
  assign CLK_ALGN_CLR_FLGS = clr_q;
  assign CLK_ALGN_TAPDLY   = tapdly_q;
  assign TRAIN_DONE        = done_q;
  assign CLK_ALGN_ERR      = err_q;
  assign ALGN_PAUSE        = pause_q;
endmodule

// File: tb/tb_icb_clk_align_multilane.sv
// tb_icb_clk_align_multilane: two-lane, 16-tap checks of sweep, window centring, skip, hold, restart and reset
module tb_icb_clk_align_multilane;
  logic       SCLK = 1'b0, RESET = 1'b1, TRAIN_START = 1'b0, CLK_ALGN_RSTRT = 1'b0, CLK_ALGN_HOLD = 1'b0, CLK_ALGN_SKIP = 1'b0;
  logic [3:0] TAP_OFFSET = '0;
  logic [1:0] IOD_EARLY, IOD_LATE, IOD_OOR;
  logic [1:0] CLK_ALGN_LOAD, CLK_ALGN_MOV, CLK_ALGN_DIR, CLK_ALGN_CLR_FLGS, CLK_ALGN_ERR;
  logic [7:0] CLK_ALGN_TAPDLY;
  logic       TRAIN_DONE, ALGN_PAUSE;
  logic [15:0] gmask [2];
  logic [3:0]  exp_res [2];
  logic [1:0]  exp_err;
  int          exp_mov [2];
  logic [3:0]  since [2];
  bit          clr_only [2];
  int          movc [2], ldc [2];
  bit          cmp_en = 1'b0, skip_mode = 1'b0;
  logic [3:0]  skip_tap = '0;
  int          errs = 0, nchk = 0;
  icb_clk_align_multilane #(.NUM_LANES(2), .TAP_CNT_WIDTH(4), .TAP_WAIT_CNT_WIDTH(1), .SKIP_TRNG(1'b0)) dut (
    .SCLK(SCLK), .RESET(RESET), .TRAIN_START(TRAIN_START), .CLK_ALGN_RSTRT(CLK_ALGN_RSTRT),
    .CLK_ALGN_HOLD(CLK_ALGN_HOLD), .CLK_ALGN_SKIP(CLK_ALGN_SKIP), .TAP_OFFSET(TAP_OFFSET),
    .IOD_EARLY(IOD_EARLY), .IOD_LATE(IOD_LATE), .IOD_OOR(IOD_OOR),
    .CLK_ALGN_LOAD(CLK_ALGN_LOAD), .CLK_ALGN_MOV(CLK_ALGN_MOV), .CLK_ALGN_DIR(CLK_ALGN_DIR),
    .CLK_ALGN_CLR_FLGS(CLK_ALGN_CLR_FLGS), .CLK_ALGN_TAPDLY(CLK_ALGN_TAPDLY), .TRAIN_DONE(TRAIN_DONE),
    .CLK_ALGN_ERR(CLK_ALGN_ERR), .ALGN_PAUSE(ALGN_PAUSE)
  );
  always #5 SCLK = ~SCLK;
  // Channel: a tap outside the lane's good mask raises one of EARLY/LATE/OOR, chosen by tap mod 3
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      IOD_EARLY[i] = !gmask[i][CLK_ALGN_TAPDLY[i*4 +: 4]] && (int'(CLK_ALGN_TAPDLY[i*4 +: 4]) % 3 == 0);
      IOD_LATE[i]  = !gmask[i][CLK_ALGN_TAPDLY[i*4 +: 4]] && (int'(CLK_ALGN_TAPDLY[i*4 +: 4]) % 3 == 1);
      IOD_OOR[i]   = !gmask[i][CLK_ALGN_TAPDLY[i*4 +: 4]] && (int'(CLK_ALGN_TAPDLY[i*4 +: 4]) % 3 == 2);
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: first contiguous good run, centre plus signed offset clamped to 0..15; sweep stops at the closing tap
  function automatic void model(input logic [15:0] m, input logic [3:0] off, output logic [3:0] r, output logic e, output int mv);
    int s, en, c;
    s = -1; en = 0; mv = 15;
    for (int t = 0; t < 16; t++) begin
      if (m[t]) begin
        if (s < 0) s = t;
        en = t;
      end else if (s >= 0) begin
        mv = t;
        break;
      end
    end
    e = (s < 0);
    c = (s + en) / 2 + int'($signed(off));
    r = e ? 4'd0 : c < 0 ? 4'd0 : c > 15 ? 4'd15 : 4'(c);
  endfunction
  task automatic clr_track();
    for (int i = 0; i < 2; i++) begin
      since[i] = '0; clr_only[i] = 1'b0; movc[i] = 0; ldc[i] = 0;
    end
  endtask
  task automatic prep(input logic [15:0] m0, input logic [15:0] m1, input logic [3:0] off, input bit sk);
    logic [3:0] r;
    logic       e;
    int         mv;
    gmask[0] = m0; gmask[1] = m1;
    TAP_OFFSET = off; CLK_ALGN_SKIP = sk; skip_mode = sk; skip_tap = off;
    for (int i = 0; i < 2; i++) begin
      model(gmask[i], off, r, e, mv);
      exp_res[i] = sk ? off : r;
      exp_err[i] = sk ? 1'b0 : e;
      exp_mov[i] = sk ? 0 : mv;
    end
    clr_track();
  endtask
  // Per-cycle compare of pulses and tap codes against the reference
  always @(negedge SCLK) begin
    if (cmp_en && !RESET) begin
      if (skip_mode) chk("skip_pause", ALGN_PAUSE, 0);
      else if (|(CLK_ALGN_LOAD | CLK_ALGN_MOV | CLK_ALGN_CLR_FLGS)) chk("one_lane", $countones(CLK_ALGN_LOAD | CLK_ALGN_MOV | CLK_ALGN_CLR_FLGS), 1);
      if (TRAIN_DONE) chk("pause_in_done", ALGN_PAUSE, 0);
      for (int i = 0; i < 2; i++) begin
        if (CLK_ALGN_MOV[i]) begin
          since[i] = since[i] + 1'b1;
          chk("mov_dir", CLK_ALGN_DIR[i], 1);
          chk("mov_clr", CLK_ALGN_CLR_FLGS[i], 1);
          chk("mov_tap", CLK_ALGN_TAPDLY[i*4 +: 4], since[i]);
          movc[i]++;
          clr_only[i] = 1'b0;
        end else if (CLK_ALGN_CLR_FLGS[i]) clr_only[i] = 1'b1;
        if (CLK_ALGN_LOAD[i]) begin
          if (skip_mode) chk("skip_load_tap", CLK_ALGN_TAPDLY[i*4 +: 4], skip_tap);
          else if (clr_only[i]) begin
            chk("start_load_tap", CLK_ALGN_TAPDLY[i*4 +: 4], 0);
            since[i] = '0;
          end else chk("final_load_tap", CLK_ALGN_TAPDLY[i*4 +: 4], exp_res[i]);
          clr_only[i] = 1'b0;
          ldc[i]++;
        end
      end
    end
  end
  task automatic start_run(input bit sk);
    @(negedge SCLK);
    TRAIN_START = 1'b1;
    @(negedge SCLK);
    if (sk) begin
      @(negedge SCLK);
      chk("skip_done_lat", TRAIN_DONE, 1);
    end else begin
      chk("launch_pause", ALGN_PAUSE, 1);
      chk("launch_done_clr", TRAIN_DONE, 0);
      chk("launch_err_clr", CLK_ALGN_ERR, 0);
      chk("clr_lat1", CLK_ALGN_CLR_FLGS, 0);
      @(negedge SCLK);
      chk("clr_lat2", CLK_ALGN_CLR_FLGS, 2'b01);
    end
    TRAIN_START = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!TRAIN_DONE && n < 3000) begin
      @(negedge SCLK);
      n++;
    end
    chk({nm, "_done"}, TRAIN_DONE, 1);
    @(negedge SCLK);
    chk({nm, "_err"}, CLK_ALGN_ERR, exp_err);
    chk({nm, "_pause"}, ALGN_PAUSE, 0);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_tap"}, CLK_ALGN_TAPDLY[i*4 +: 4], exp_res[i]);
      chk({nm, "_moves"}, movc[i], exp_mov[i]);
      chk({nm, "_loads"}, ldc[i], skip_mode ? 1 : 2);
    end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_load"}, CLK_ALGN_LOAD, 0);
    chk({nm, "_mov"}, CLK_ALGN_MOV, 0);
    chk({nm, "_clr"}, CLK_ALGN_CLR_FLGS, 0);
    chk({nm, "_dir"}, CLK_ALGN_DIR, 2'b11);
    chk({nm, "_tap"}, CLK_ALGN_TAPDLY, 0);
    chk({nm, "_done"}, TRAIN_DONE, 0);
    chk({nm, "_err"}, CLK_ALGN_ERR, 0);
    chk({nm, "_pause"}, ALGN_PAUSE, 0);
  endtask
  initial begin
    logic [7:0] snap;
    int n;
    gmask[0] = '0; gmask[1] = '0;
    clr_track();
    repeat (3) @(negedge SCLK);
    chk_reset("rst");
    RESET = 1'b0;
    cmp_en = 1'b1;
    prep(16'h03E0, 16'h000C, 4'd0, 1'b0);
    start_run(1'b0);
    wait_done("t1");
    chk("t1_lit", CLK_ALGN_TAPDLY, 8'h27);
    chk("t1_lit_mov0", movc[0], 10);
    prep(16'h0000, 16'h000C, 4'd0, 1'b0);
    start_run(1'b0);
    wait_done("t2");
    chk("t2_lit_err", CLK_ALGN_ERR, 2'b01);
    chk("t2_lit_tap", CLK_ALGN_TAPDLY, 8'h20);
    prep(16'hF000, 16'h0670, 4'd3, 1'b0);
    start_run(1'b0);
    wait_done("t3a");
    chk("t3a_lit", CLK_ALGN_TAPDLY, 8'h8F);
    prep(16'h0003, 16'h3F00, 4'hE, 1'b0);
    start_run(1'b0);
    wait_done("t3b");
    chk("t3b_lit", CLK_ALGN_TAPDLY, 8'h80);
    prep(16'h03E0, 16'h000C, 4'd6, 1'b1);
    start_run(1'b1);
    wait_done("t4");
    chk("t4_lit", CLK_ALGN_TAPDLY, 8'h66);
    prep(16'h03E0, 16'h000C, 4'd0, 1'b0);
    start_run(1'b0);
    repeat (30) @(negedge SCLK);
    CLK_ALGN_HOLD = 1'b1;
    @(negedge SCLK);
    snap = CLK_ALGN_TAPDLY;
    repeat (20) begin
      @(negedge SCLK);
      chk("hold_quiet", {CLK_ALGN_LOAD, CLK_ALGN_MOV, CLK_ALGN_CLR_FLGS}, 0);
      chk("hold_tap", CLK_ALGN_TAPDLY, snap);
    end
    CLK_ALGN_HOLD = 1'b0;
    wait_done("t5");
    chk("t5_lit", CLK_ALGN_TAPDLY, 8'h27);
    prep(16'h0000, 16'h000C, 4'd0, 1'b0);
    start_run(1'b0);
    n = 0;
    while (!CLK_ALGN_CLR_FLGS[1] && n < 1000) begin
      @(negedge SCLK);
      n++;
    end
    chk("reach_lane1", CLK_ALGN_CLR_FLGS[1], 1);
    repeat (5) @(negedge SCLK);
    chk("pre_rstrt_err", CLK_ALGN_ERR, 2'b01);
    CLK_ALGN_RSTRT = 1'b1;
    @(negedge SCLK);
    chk("rstrt_err", CLK_ALGN_ERR, 0);
    chk("rstrt_pause", ALGN_PAUSE, 1);
    chk("rstrt_done", TRAIN_DONE, 0);
    clr_track();
    repeat (2) @(negedge SCLK);
    chk("rstrt_quiet", {CLK_ALGN_LOAD, CLK_ALGN_MOV, CLK_ALGN_CLR_FLGS}, 0);
    CLK_ALGN_RSTRT = 1'b0;
    @(negedge SCLK);
    chk("rstrt_lane0", CLK_ALGN_CLR_FLGS, 2'b01);
    wait_done("t6");
    prep(16'h0000, 16'h0FF0, 4'd0, 1'b0);
    start_run(1'b0);
    repeat (100) @(negedge SCLK);
    chk("pre_reset_err", CLK_ALGN_ERR, 2'b01);
    chk("pre_reset_pause", ALGN_PAUSE, 1);
    #2 RESET = 1'b1;
    #1 chk_reset("async_rst");
    @(negedge SCLK);
    RESET = 1'b0;
    prep(16'h03E0, 16'h000C, 4'd0, 1'b0);
    start_run(1'b0);
    wait_done("t7");
    chk("t7_lit", CLK_ALGN_TAPDLY, 8'h27);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
